vector_packet_scheduler: RTL and testbench

// Shares one AXI-Stream master between NUM_SRC requesters. Each requester

---
 rtl/vector_packet_scheduler.sv | 110 +++++++++++
 tb/tb_vector_packet_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_packet_scheduler.sv
`timescale 1ns/1ps
// Round-robin share of one AXIS master among NUM_SRC vector requesters; the grant lands one cycle after req (IDLE),
// each vector goes out as VEC_BYTES/AXIS_BYTES beats, and a beat holds stable under !tready; src_ack pulses on the final handshake.
module vector_packet_scheduler #(
    parameter int NUM_SRC    = 2,
    parameter int VEC_BYTES  = 4,
    parameter int AXIS_BYTES = 1,
    parameter bit MSB_FIRST  = 1'b0,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [NUM_SRC-1:0]             src_req,
    input  logic [NUM_SRC*VEC_BYTES*8-1:0] src_vec,
    output logic [NUM_SRC-1:0]             src_ack,
    output logic                           busy,
    output logic [SRC_W-1:0]               cur_src,
    input  logic                           axis_tready,
    output logic                           axis_tvalid,
    output logic [AXIS_BYTES*8-1:0]        axis_tdata,
    output logic [AXIS_BYTES-1:0]          axis_tkeep,
    output logic                           axis_tlast
);
    localparam int NBEATS = VEC_BYTES / AXIS_BYTES;
    localparam int BEAT_W = AXIS_BYTES * 8;
    localparam int CTR_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CTR_W-1:0] FIRST_BEAT = MSB_FIRST ? CTR_W'(NBEATS - 1) : '0;
    localparam logic [CTR_W-1:0] LAST_BEAT  = MSB_FIRST ? '0 : CTR_W'(NBEATS - 1);

    generate
        if (VEC_BYTES % AXIS_BYTES != 0) begin : g_bad_width
            $error("VEC_BYTES must be a multiple of AXIS_BYTES");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t                                       state;
    logic [SRC_W-1:0]                             rr_ptr;
    logic [CTR_W-1:0]                             ctr;
    logic [NBEATS-1:0][BEAT_W-1:0]                hold_vec;
    logic [NUM_SRC-1:0][NBEATS-1:0][BEAT_W-1:0]   src_arr;
    logic                                         grant_vld;
    logic [SRC_W-1:0]                             grant;
    logic [SRC_W-1:0]                             cand;
    logic                                         last_beat;

    assign src_arr     = src_vec;
    assign last_beat   = (ctr == LAST_BEAT);
    assign axis_tvalid = (state == SEND);
    assign busy        = (state == SEND);
    assign axis_tdata  = hold_vec[ctr];
    assign axis_tlast  = (state == SEND) && last_beat;
    assign axis_tkeep  = '1;

    // First requester at or after rr_ptr, wrapping past NUM_SRC-1.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_vld && src_req[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        src_ack = '0;
        if (state == SEND && axis_tready && last_beat) begin
            src_ack[cur_src] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cur_src  <= '0;
            ctr      <= '0;
            hold_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        hold_vec <= src_arr[grant];
                        cur_src  <= grant;
                        ctr      <= FIRST_BEAT;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (axis_tready) begin
                        if (last_beat) begin
                            rr_ptr <= (int'(cur_src) == NUM_SRC - 1) ? '0 : cur_src + SRC_W'(1);
                            state  <= IDLE;
                        end else if (MSB_FIRST) begin
                            ctr <= ctr - CTR_W'(1);
                        end else begin
                            ctr <= ctr + CTR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_packet_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench: expected beats are queued when a request is raised and popped at each AXIS handshake.
module tb_vector_packet_scheduler;
    logic        clk = 1'b0;
    logic        aresetn;
    logic [1:0]  src_req, req_m;
    logic [63:0] src_vec;
    logic        tready, tready_m;

    logic [1:0]  ack0, ack1;
    logic        busy0, busy1;
    logic [0:0]  cur0, cur1;
    logic        tvalid0, tvalid1, tlast0, tlast1;
    logic [7:0]  tdata0, tdata1;
    logic [0:0]  tkeep0, tkeep1;

    always #5 clk = ~clk;

    vector_packet_scheduler #(.NUM_SRC(2), .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .aresetn(aresetn), .src_req(src_req), .src_vec(src_vec),
        .src_ack(ack0), .busy(busy0), .cur_src(cur0), .axis_tready(tready),
        .axis_tvalid(tvalid0), .axis_tdata(tdata0), .axis_tkeep(tkeep0), .axis_tlast(tlast0)
    );

    vector_packet_scheduler #(.NUM_SRC(2), .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .aresetn(aresetn), .src_req(req_m), .src_vec(src_vec),
        .src_ack(ack1), .busy(busy1), .cur_src(cur1), .axis_tready(tready_m),
        .axis_tvalid(tvalid1), .axis_tdata(tdata1), .axis_tkeep(tkeep1), .axis_tlast(tlast1)
    );

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
        logic       src;
    } beat_t;

    beat_t      q[$];
    beat_t      exp;
    logic [1:0] exp_ack;
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic push_pkt(input logic [31:0] v, input logic s, input bit msb);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.dat  = msb ? v[(3 - i) * 8 +: 8] : v[i * 8 +: 8];
            b.last = (i == 3);
            b.src  = s;
            q.push_back(b);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; src_req = 2'b00; req_m = 2'b00;
        tready = 1'b1; tready_m = 1'b1; src_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({tvalid0, tlast0, busy0, ack0, cur0} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_dut: tvalid=%b tlast=%b busy=%b ack=%b cur=%b, required all 0",
                     tvalid0, tlast0, busy0, ack0, cur0);
        end
        vectors++;
        if ({tvalid1, tlast1, busy1, ack1, cur1} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_msb: tvalid=%b tlast=%b busy=%b ack=%b cur=%b, required all 0",
                     tvalid1, tlast1, busy1, ack1, cur1);
        end
        vectors++;
        if (tkeep0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tkeep: got %b, required 1", tkeep0);
        end
        @(negedge clk) aresetn = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (tvalid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: tvalid=%b, required 0", tvalid0);
        end
    endtask

    task automatic test_alternate();
        int acks = 0;
        bit prev_last = 0;
        bit gap = 0;
        src_vec = {32'h88776655, 32'h44332211};
        push_pkt(32'h44332211, 1'b0, 0); push_pkt(32'h88776655, 1'b1, 0);
        push_pkt(32'h44332211, 1'b0, 0); push_pkt(32'h88776655, 1'b1, 0);
        src_req = 2'b11;
        for (int cyc = 0; cyc < 200 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (gap) begin
                gap = 0;
                vectors++;
                if (tvalid0 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL alt_regrant: tvalid=%b, required 1", tvalid0);
                end
            end
            if (prev_last) begin
                prev_last = 0;
                gap = 1;
                vectors++;
                if (tvalid0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL alt_gap: tvalid=%b, required 0", tvalid0);
                end
            end
            if (tvalid0 && tready) begin
                exp = q.pop_front();
                exp_ack = exp.last ? (2'b01 << exp.src) : 2'b00;
                vectors++;
                if (tdata0 !== exp.dat || tlast0 !== exp.last || cur0 !== exp.src || ack0 !== exp_ack) begin
                    miscompares++;
                    $display("FAIL alt_beat: data=%h last=%b src=%b ack=%b, required data=%h last=%b src=%b ack=%b",
                             tdata0, tlast0, cur0, ack0, exp.dat, exp.last, exp.src, exp_ack);
                end
                if (exp.last) begin
                    prev_last = 1;
                    acks++;
                end
            end
            @(posedge clk); #1;
            if (acks == 4) src_req = 2'b00;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL alt_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
        src_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit drop = 0;
        src_vec[31:0] = 32'h44332211;
        push_pkt(32'h44332211, 1'b0, 0);
        src_req = 2'b01;
        for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (tvalid0 && tready) begin
                exp = q.pop_front();
                exp_ack = exp.last ? (2'b01 << exp.src) : 2'b00;
                vectors++;
                if (tdata0 !== exp.dat || tlast0 !== exp.last || cur0 !== exp.src || ack0 !== exp_ack) begin
                    miscompares++;
                    $display("FAIL single_beat: data=%h last=%b src=%b ack=%b, required data=%h last=%b src=%b ack=%b",
                             tdata0, tlast0, cur0, ack0, exp.dat, exp.last, exp.src, exp_ack);
                end
                drop = exp.last;
            end
            @(posedge clk); #1;
            if (drop) src_req = 2'b00;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL single_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
        src_req = 2'b00;
        @(negedge clk);
        vectors++;
        if (tvalid0 !== 1'b0 || ack0 !== 2'b00) begin
            miscompares++;
            $display("FAIL single_idle: tvalid=%b ack=%b, required 0 and 00", tvalid0, ack0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_msb_first();
        bit drop = 0;
        src_vec[31:0] = 32'h44332211;
        push_pkt(32'h44332211, 1'b0, 1);
        req_m = 2'b01;
        for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (tvalid1 && tready_m) begin
                exp = q.pop_front();
                exp_ack = exp.last ? (2'b01 << exp.src) : 2'b00;
                vectors++;
                if (tdata1 !== exp.dat || tlast1 !== exp.last || cur1 !== exp.src || ack1 !== exp_ack) begin
                    miscompares++;
                    $display("FAIL msb_beat: data=%h last=%b src=%b ack=%b, required data=%h last=%b src=%b ack=%b",
                             tdata1, tlast1, cur1, ack1, exp.dat, exp.last, exp.src, exp_ack);
                end
                drop = exp.last;
            end
            @(posedge clk); #1;
            if (drop) req_m = 2'b00;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL msb_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
        req_m = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int  pat[4] = '{1, 0, 0, 1};
        int  p = 1;
        bit  drop = 0;
        bit  stalled = 0;
        logic [7:0] held_d;
        logic       held_l;
        src_vec[31:0] = 32'h44332211;
        push_pkt(32'h44332211, 1'b0, 0);
        tready = 1'b1;
        src_req = 2'b01;
        for (int cyc = 0; cyc < 80 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                vectors++;
                if (tvalid0 !== 1'b1 || tdata0 !== held_d || tlast0 !== held_l) begin
                    miscompares++;
                    $display("FAIL bp_stable: tvalid=%b data=%h last=%b, required 1 %h %b",
                             tvalid0, tdata0, tlast0, held_d, held_l);
                end
            end
            stalled = 0;
            if (tvalid0 && !tready) begin
                stalled = 1;
                held_d = tdata0;
                held_l = tlast0;
                vectors++;
                if (ack0 !== 2'b00) begin
                    miscompares++;
                    $display("FAIL bp_ack_stall: ack=%b, required 00", ack0);
                end
            end else if (tvalid0 && tready) begin
                exp = q.pop_front();
                exp_ack = exp.last ? (2'b01 << exp.src) : 2'b00;
                vectors++;
                if (tdata0 !== exp.dat || tlast0 !== exp.last || cur0 !== exp.src || ack0 !== exp_ack) begin
                    miscompares++;
                    $display("FAIL bp_beat: data=%h last=%b src=%b ack=%b, required data=%h last=%b src=%b ack=%b",
                             tdata0, tlast0, cur0, ack0, exp.dat, exp.last, exp.src, exp_ack);
                end
                drop = exp.last;
            end
            @(posedge clk); #1;
            if (drop) src_req = 2'b00;
            tready = (pat[p] != 0);
            p = (p + 1) % 4;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
        src_req = 2'b00;
        tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_vec_change();
        int  acks = 0;
        bit  changed = 0;
        src_vec[31:0] = 32'h44332211;
        push_pkt(32'h44332211, 1'b0, 0);
        push_pkt(32'hDEADBEEF, 1'b0, 0);
        src_req = 2'b01;
        for (int cyc = 0; cyc < 80 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (tvalid0 && tready) begin
                exp = q.pop_front();
                exp_ack = exp.last ? (2'b01 << exp.src) : 2'b00;
                vectors++;
                if (tdata0 !== exp.dat || tlast0 !== exp.last || cur0 !== exp.src || ack0 !== exp_ack) begin
                    miscompares++;
                    $display("FAIL vec_change_beat: data=%h last=%b src=%b ack=%b, required data=%h last=%b src=%b ack=%b",
                             tdata0, tlast0, cur0, ack0, exp.dat, exp.last, exp.src, exp_ack);
                end
                if (exp.last) acks++;
            end
            @(posedge clk); #1;
            if (!changed && tvalid0) begin
                src_vec[31:0] = 32'hDEADBEEF;
                changed = 1;
            end
            if (acks == 2) src_req = 2'b00;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL vec_change_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
        src_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int  popped = 0;
        bit  drop = 0;
        src_vec[31:0] = 32'h44332211;
        push_pkt(32'h44332211, 1'b0, 0);
        src_req = 2'b01;
        for (int cyc = 0; cyc < 40 && popped < 2; cyc++) begin
            @(negedge clk);
            if (tvalid0 && tready) begin
                exp = q.pop_front();
                popped++;
                vectors++;
                if (tdata0 !== exp.dat || ack0 !== 2'b00) begin
                    miscompares++;
                    $display("FAIL abort_pre: data=%h ack=%b, required data=%h ack=00", tdata0, ack0, exp.dat);
                end
            end
            @(posedge clk); #1;
        end
        if (popped != 2) begin
            miscompares++;
            $display("FAIL abort_timeout: %0d beats seen, required 2", popped);
        end
        #1 aresetn = 1'b0;
        #1;
        vectors++;
        if ({tvalid0, tlast0, busy0, ack0, cur0} !== 6'b0) begin
            miscompares++;
            $display("FAIL abort_async: tvalid=%b tlast=%b busy=%b ack=%b cur=%b, required all 0",
                     tvalid0, tlast0, busy0, ack0, cur0);
        end
        q.delete();
        @(negedge clk);
        vectors++;
        if (tvalid0 !== 1'b0 || ack0 !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_hold: tvalid=%b ack=%b, required 0 and 00", tvalid0, ack0);
        end
        aresetn = 1'b1;
        push_pkt(32'h44332211, 1'b0, 0);
        for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (tvalid0 && tready) begin
                exp = q.pop_front();
                exp_ack = exp.last ? (2'b01 << exp.src) : 2'b00;
                vectors++;
                if (tdata0 !== exp.dat || tlast0 !== exp.last || cur0 !== exp.src || ack0 !== exp_ack) begin
                    miscompares++;
                    $display("FAIL restart_beat: data=%h last=%b src=%b ack=%b, required data=%h last=%b src=%b ack=%b",
                             tdata0, tlast0, cur0, ack0, exp.dat, exp.last, exp.src, exp_ack);
                end
                drop = exp.last;
            end
            @(posedge clk); #1;
            if (drop) src_req = 2'b00;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL restart_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
        src_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_msb_first();
        test_backpressure();
        test_vec_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
